// File: rtl/string_hw_pkg.sv
// Shared constants and types for the string accelerator loader.
// Window bases are word addresses in the accelerator slave map.
`timescale 1ns/1ps
package string_hw_pkg;
    localparam int MAX_WORDS    = 8;
    localparam int ADDRESS_BITS = 4;
    localparam int STRA_BASE    = 1;
    localparam int STRB_BASE    = MAX_WORDS + 1;

    typedef enum logic [2:0] {IDLE, READ, WRITE, FILL, DONE} fetch_state_t;
endpackage

// File: rtl/nul_byte_finder.sv
// Locates the lowest 0x00 byte of a little-endian word and blanks that byte
// and every byte above it.
`timescale 1ns/1ps
module nul_byte_finder (
    input  logic [31:0] word,
    output logic        found,
    output logic [1:0]  pos,
    output logic [31:0] masked
);
    always_comb begin
        found  = 1'b0;
        pos    = 2'd0;
        masked = word;
        // Scan downward so the lowest zero byte is the one that sticks.
        for (int i = 3; i >= 0; i--) begin
            if (word[8*i +: 8] == 8'h00) begin
                found = 1'b1;
                pos   = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (found && (2'(i) >= pos)) masked[8*i +: 8] = 8'h00;
        end
    end
endmodule

// File: rtl/string_fetch_master.sv
// Fetches a NUL-terminated string over an Avalon-MM read port and copies it,
// masked and zero-filled, into the StringA/StringB accelerator register window.
`timescale 1ns/1ps
module string_fetch_master #(
    parameter int MAX_WORDS    = 8,
    parameter int ADDRESS_BITS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [31:0]                  src_addr,
    input  logic                         dst_sel,
    output logic                         busy,
    output logic                         done,
    output logic [7:0]                   length,
    output logic                         truncated,
    output logic [31:0]                  m_address,
    output logic                         m_read,
    input  logic                         m_waitrequest,
    input  logic [31:0]                  m_readdata,
    output logic [ADDRESS_BITS:0]        acc_address,
    output logic                         acc_write,
    output logic                         acc_chipselect,
    output logic [31:0]                  acc_writedata,
    output string_hw_pkg::fetch_state_t  state_dbg
);
    import string_hw_pkg::*;

    localparam int IDX_W = $clog2(MAX_WORDS);
    localparam int AW    = ADDRESS_BITS + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_WORDS - 1);

    fetch_state_t     state;
    logic [31:0]      src_q;
    logic             dst_q;
    logic [IDX_W-1:0] word_idx;
    logic [7:0]       byte_cnt;
    logic             rd_found;
    logic [1:0]       rd_pos;

    logic             nb_found;
    logic [1:0]       nb_pos;
    logic [31:0]      nb_masked;
    logic [AW-1:0]    base;
    logic [7:0]       cnt_next;
    logic [IDX_W-1:0] idx_inc;

    nul_byte_finder u_finder (
        .word   (m_readdata),
        .found  (nb_found),
        .pos    (nb_pos),
        .masked (nb_masked)
    );

    always_comb begin
        base     = dst_q ? AW'(MAX_WORDS + 1) : AW'(STRA_BASE);
        cnt_next = byte_cnt + (rd_found ? 8'(rd_pos) : 8'd4);
        idx_inc  = word_idx + 1'b1;
    end

    assign state_dbg = state;

    // Avalon read handshake: a word is taken only in the cycle where
    // m_read && !m_waitrequest; m_read and m_address stay frozen until then,
    // and m_read drops right after, so at most one read is ever in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            src_q          <= '0;
            dst_q          <= 1'b0;
            word_idx       <= '0;
            byte_cnt       <= '0;
            rd_found       <= 1'b0;
            rd_pos         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            length         <= '0;
            truncated      <= 1'b0;
            m_address      <= '0;
            m_read         <= 1'b0;
            acc_address    <= '0;
            acc_write      <= 1'b0;
            acc_chipselect <= 1'b0;
            acc_writedata  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    src_q     <= src_addr;
                    dst_q     <= dst_sel;
                    word_idx  <= '0;
                    byte_cnt  <= '0;
                    m_address <= src_addr;
                    m_read    <= 1'b1;
                    busy      <= 1'b1;
                    state     <= READ;
                end
                READ: if (!m_waitrequest) begin
                    m_read         <= 1'b0;
                    rd_found       <= nb_found;
                    rd_pos         <= nb_pos;
                    acc_write      <= 1'b1;
                    acc_chipselect <= 1'b1;
                    acc_address    <= base + AW'(word_idx);
                    acc_writedata  <= nb_masked;
                    state          <= WRITE;
                end
                WRITE: begin
                    byte_cnt <= cnt_next;
                    if (rd_found && (word_idx != LAST_IDX)) begin
                        word_idx      <= idx_inc;
                        acc_address   <= base + AW'(idx_inc);
                        acc_writedata <= '0;
                        state         <= FILL;
                    end else if (rd_found || (word_idx == LAST_IDX)) begin
                        acc_write      <= 1'b0;
                        acc_chipselect <= 1'b0;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        length         <= cnt_next;
                        truncated      <= !rd_found;
                        state          <= DONE;
                    end else begin
                        acc_write      <= 1'b0;
                        acc_chipselect <= 1'b0;
                        word_idx       <= idx_inc;
                        m_address      <= src_q + (32'(idx_inc) << 2);
                        m_read         <= 1'b1;
                        state          <= READ;
                    end
                end
                FILL: begin
                    if (word_idx == LAST_IDX) begin
                        acc_write      <= 1'b0;
                        acc_chipselect <= 1'b0;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        length         <= byte_cnt;
                        truncated      <= 1'b0;
                        state          <= DONE;
                    end else begin
                        word_idx    <= idx_inc;
                        acc_address <= base + AW'(idx_inc);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/string_fetch_master.md
Name: string_fetch_master

Overview:
- Upstream loader for the string accelerator's register bank.
- On a start command it reads a NUL-terminated string from system memory over an Avalon-MM master read port.
- It masks bytes after the terminator and writes the string word by word into the StringA or StringB register window, zero-filling unused words.
- It reports the byte length, which software copies into the accelerator control length field (8 bits).

Parameters:
MAX_WORDS, 8, words per string register window (32 bytes max)
ADDRESS_BITS, 4, MSB index of the accelerator slave address (address width = ADDRESS_BITS+1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request; sampled only in IDLE
src_addr  input  32  byte address of the string in memory; must be word-aligned
dst_sel  input  1  0 = StringA window (base 1), 1 = StringB window (base MAX_WORDS+1)
busy  output  1  high from the cycle after an accepted start until DONE exits
done  output  1  one-cycle pulse when the transfer completes
length  output  8  bytes before the first NUL; held until the next accepted start
truncated  output  1  no NUL found within MAX_WORDS words; held like length
m_address  output  32  master read address
m_read  output  1  master read request
m_waitrequest  input  1  slave stall
m_readdata  input  32  read data, valid in the cycle m_read && !m_waitrequest
acc_address  output  ADDRESS_BITS+1  accelerator slave word address
acc_write  output  1  accelerator write strobe
acc_chipselect  output  1  equals acc_write
acc_writedata  output  32  word to store

Behaviour:
- Reset values: busy, done, m_read, acc_write, acc_chipselect = 0; m_address, acc_address, acc_writedata, length = 0; truncated = 0; state = IDLE.
- Byte order: little-endian. Byte 0 = bits[7:0] is the first character.
- States: IDLE, READ, WRITE, FILL, DONE.
- IDLE:
  - On start, latch src_addr, dst_sel, word_idx = 0, byte_cnt = 0; go to READ.
  - start while not IDLE is ignored.
- READ:
  - Hold m_read = 1 and m_address = src_addr + 4*word_idx.
  - Hold both stable while m_waitrequest = 1.
  - On m_read && !m_waitrequest: capture the word, drop m_read, go to WRITE. No pipelined or outstanding reads.
- WRITE (exactly 1 cycle):
  - acc_write = 1, acc_address = base + word_idx.
  - acc_writedata = captured word with the first 0x00 byte and all higher bytes forced to 0x00.
  - If the word contains a NUL at byte position k: byte_cnt += k, then go to FILL if word_idx < MAX_WORDS-1, else DONE.
  - Otherwise byte_cnt += 4. If word_idx == MAX_WORDS-1, set truncated and go to DONE; else word_idx++ and go to READ.
- FILL:
  - One acc_write per cycle with writedata = 0 for word_idx+1 .. MAX_WORDS-1, then go to DONE.
  - No master reads are issued past the word containing the NUL.
- DONE (1 cycle):
  - done = 1, length = byte_cnt, truncated updated; next state IDLE.
  - busy drops in the same cycle done is asserted.
- Latency with zero wait states: 2 cycles per word read, plus 1 cycle per filled word, plus 1 DONE cycle.
  - Example: "Hi" at MAX_WORDS=8 = 2 + 7 + 1 = 10 cycles after the start edge.
- Arithmetic:
  - byte_cnt max 32, fits in 8 bits.
  - acc_address base + word_idx max 2*MAX_WORDS = 16, fits in 5 bits.
  - m_address wraps modulo 2^32 with no error.
- Empty string (first byte 0x00): all MAX_WORDS words written as 0, length = 0, truncated = 0.
- Reset mid-operation: immediate return to IDLE. m_read and acc_write deassert in the next cycle. Partially written words remain in the accelerator. No done pulse.
- A string of exactly 4*MAX_WORDS bytes with no NUL gives length = 32, truncated = 1.

Decomposition:
- Package string_hw_pkg:
  - MAX_WORDS, ADDRESS_BITS.
  - STRA_BASE = 1, STRB_BASE = MAX_WORDS+1.
  - fetch_state_t enum {IDLE, READ, WRITE, FILL, DONE}.
- Sub-module nul_byte_finder (combinational):
  - Input: 32-bit word.
  - Outputs: found, pos[1:0] (lowest zero byte), masked word.

Test Plan:
- "Hi\0" at 0x100, dst_sel = 0, no wait states -> writes addr1 = 0x00006948, addr2..8 = 0; length = 2; done on cycle 10; truncated = 0.
- 31-char string, dst_sel = 1, NUL at byte 3 of word 7 -> writes addr9..16, last word has byte 3 = 0, no FILL; length = 31.
- 32 non-zero bytes -> 8 reads, 8 writes, length = 32, truncated = 1; no ninth read issued.
- m_waitrequest held 3 cycles on every read -> m_address and m_read stable while stalled; data captured only on the release cycle; results identical to the zero-wait case.
- Word 0x41004200 (byte 0 = NUL) -> all zero words written, length = 0; start pulsed again while busy is ignored.
- reset asserted during FILL -> next cycle IDLE, acc_write = 0, busy = 0, no done; a following start runs normally.
